alu_execucao: RTL

Sequential execute-stage ALU for the MIPS pipeline: the consumer of the 4-bit ALU control code produced by the ALU control decoder. Accepts operands plus control code through a valid/ready handshake and registers the result, zero flag and signed overflow. Single-cycle ops complete in one clock; an iterative multiply (code 1001) takes WIDTH clocks. The output register holds its value under downstream stall.

---
 rtl/alu_execucao.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_execucao.sv
// Execute-stage ALU: valid/ready operand intake, single-cycle arithmetic/logic ops
// and an iterative shift-add multiply, with a stall-holding output register.
module alu_execucao #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Entrada_Valida,
  output logic             Entrada_Pronta,
  input  logic [3:0]       Controle_ALU,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Saida_Valida,
  input  logic             Saida_Pronta,
  output logic [WIDTH-1:0] Resultado,
  output logic             Zero,
  output logic             Overflow,
  output logic             Erro
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ULTIMA = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic [0:0] {
    OCIOSO,
    MULT
  } estado_t;

  estado_t          estado;
  estado_t          proximo_estado;

  logic [WIDTH-1:0] multiplicando;
  logic [WIDTH-1:0] multiplicador;
  logic [WIDTH-1:0] acumulador;
  logic [WIDTH-1:0] acumulado_prox;
  logic [CW-1:0]    contador;

  logic             aceita;
  logic             eh_mul;
  logic             conclui_simples;
  logic             ultima_iter;

  logic [WIDTH-1:0] soma;
  logic [WIDTH-1:0] diferenca;
  logic [WIDTH-1:0] res_comb;
  logic             ovf_comb;
  logic             erro_comb;

  // The output slot frees and a new word can enter in the same cycle.
  assign Entrada_Pronta  = (estado == OCIOSO) && (!Saida_Valida || Saida_Pronta);
  assign aceita          = Entrada_Valida && Entrada_Pronta;
  assign eh_mul          = (Controle_ALU == OP_MUL);
  assign conclui_simples = aceita && !eh_mul;
  assign ultima_iter     = (estado == MULT) && (contador == ULTIMA);

  assign soma      = A + B;
  assign diferenca = A - B;

  always_comb begin
    res_comb  = '0;
    ovf_comb  = 1'b0;
    erro_comb = 1'b0;
    case (Controle_ALU)
      OP_ADD: begin
        res_comb = soma;
        ovf_comb = (A[WIDTH-1] == B[WIDTH-1]) && (soma[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res_comb = diferenca;
        ovf_comb = (A[WIDTH-1] != B[WIDTH-1]) && (diferenca[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  res_comb = A & B;
      OP_OR:   res_comb = A | B;
      OP_NOR:  res_comb = ~(A | B);
      OP_XOR:  res_comb = A ^ B;
      OP_SLT:  res_comb = WIDTH'($signed(A) < $signed(B));
      OP_MUL:  res_comb = '0;
      default: erro_comb = 1'b1;
    endcase
  end

  // The final iteration's add is folded into the value loaded into Resultado.
  assign acumulado_prox = acumulador + (multiplicador[0] ? multiplicando : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= proximo_estado;
    end
  end

  always_comb begin
    proximo_estado = estado;
    case (estado)
      OCIOSO:  if (aceita && eh_mul) proximo_estado = MULT;
      MULT:    if (ultima_iter) proximo_estado = OCIOSO;
      default: proximo_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      multiplicando <= '0;
      multiplicador <= '0;
      acumulador    <= '0;
      contador      <= '0;
    end else if (aceita && eh_mul) begin
      multiplicando <= A;
      multiplicador <= B;
      acumulador    <= '0;
      contador      <= '0;
    end else if (estado == MULT) begin
      acumulador    <= acumulado_prox;
      multiplicando <= multiplicando << 1;
      multiplicador <= multiplicador >> 1;
      contador      <= contador + CW'(1);
    end
  end

  // A consumed result is replaced directly by a completing op, so no bubble is inserted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Resultado    <= '0;
      Zero         <= 1'b1;
      Overflow     <= 1'b0;
      Erro         <= 1'b0;
      Saida_Valida <= 1'b0;
    end else if (conclui_simples) begin
      Resultado    <= res_comb;
      Zero         <= (res_comb == '0);
      Overflow     <= ovf_comb;
      Erro         <= erro_comb;
      Saida_Valida <= 1'b1;
    end else if (ultima_iter) begin
      Resultado    <= acumulado_prox;
      Zero         <= (acumulado_prox == '0);
      Overflow     <= 1'b0;
      Erro         <= 1'b0;
      Saida_Valida <= 1'b1;
    end else if (Saida_Valida && Saida_Pronta) begin
      Saida_Valida <= 1'b0;
    end
  end

endmodule
